// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM encodings and the
// IO register offsets used by the memory-map decoder.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitHigh = 3'd4
  } rxState_t;

  // Offsets within the UART IO window; 0x4 is the rx valid flag, 0xC the rx byte.
  localparam logic [3:0] IoOffset00 = 4'h0;
  localparam logic [3:0] IoOffset04 = 4'h4;
  localparam logic [3:0] IoOffset08 = 4'h8;
  localparam logic [3:0] IoOffset0C = 4'hC;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to 1 so an
// idle-high line does not look like a start bit coming out of reset.
module uart_sync2 (
  input  logic Clock,
  input  logic Reset_n,
  input  logic rawLine,
  output logic syncLine
);

  logic meta;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      meta     <= 1'b1;
      syncLine <= 1'b1;
    end else begin
      meta     <= rawLine;
      syncLine <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronized line, baud-timed sampling FSM and a
// one-entry holding register with overrun and framing-error pulses.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       SerialIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  output logic       FramingError,
  output logic       Overrun,
  output logic [2:0] StateDebug
);

  localparam int SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int SampleTime     = SymbolEdgeTime / 2;
  localparam int CntWidth       = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
  localparam logic [CntWidth-1:0] SymbolLast = CntWidth'(SymbolEdgeTime - 1);
  localparam logic [CntWidth-1:0] SampleLast = CntWidth'(SampleTime - 1);

  logic                line;
  rxState_t            state, stateNext;
  logic [CntWidth-1:0] clkCnt, clkCntNext;
  logic [2:0]          bitCnt, bitCntNext;
  logic [7:0]          shift, shiftNext;
  logic                frameDone, frameDoneNext;
  logic                stopOk, stopOkNext;

  uart_sync2 u_sync (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .rawLine  (SerialIn),
    .syncLine (line)
  );

  assign StateDebug = state;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= StIdle;
      clkCnt    <= '0;
      bitCnt    <= 3'd0;
      shift     <= 8'h00;
      frameDone <= 1'b0;
      stopOk    <= 1'b0;
    end else begin
      state     <= stateNext;
      clkCnt    <= clkCntNext;
      bitCnt    <= bitCntNext;
      shift     <= shiftNext;
      frameDone <= frameDoneNext;
      stopOk    <= stopOkNext;
    end
  end

  always_comb begin
    stateNext     = state;
    clkCntNext    = clkCnt + CntWidth'(1);
    bitCntNext    = bitCnt;
    shiftNext     = shift;
    frameDoneNext = 1'b0;
    stopOkNext    = 1'b0;
    case (state)
      StIdle: begin
        clkCntNext = '0;
        if (!line) stateNext = StStart;
      end
      StStart: begin
        if (clkCnt == SampleLast) begin
          clkCntNext = '0;
          bitCntNext = 3'd0;
          stateNext  = line ? StIdle : StData;
        end
      end
      StData: begin
        if (clkCnt == SymbolLast) begin
          clkCntNext = '0;
          shiftNext  = {line, shift[7:1]};
          if (bitCnt == 3'd7) stateNext = StStop;
          else                bitCntNext = bitCnt + 3'd1;
        end
      end
      StStop: begin
        // The verdict is registered here and applied to the holding register one edge later.
        if (clkCnt == SymbolLast) begin
          clkCntNext    = '0;
          frameDoneNext = 1'b1;
          stopOkNext    = line;
          stateNext     = line ? StIdle : StWaitHigh;
        end
      end
      StWaitHigh: begin
        clkCntNext = '0;
        if (line) stateNext = StIdle;
      end
      default: begin
        clkCntNext = '0;
        stateNext  = StIdle;
      end
    endcase
  end

  // Handshake: a byte is transferred on every rising edge where DataOutValid and
  // DataOutReady are both 1; DataOut is stable while DataOutValid is 1 unless the
  // same edge both consumes and refills the register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      DataOut      <= 8'h00;
      DataOutValid <= 1'b0;
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      FramingError <= frameDone && !stopOk;
      Overrun      <= frameDone && stopOk && DataOutValid && !DataOutReady;
      if (frameDone && stopOk && (!DataOutValid || DataOutReady)) begin
        DataOut      <= shift;
        DataOutValid <= 1'b1;
      end else if (DataOutValid && DataOutReady) begin
        DataOutValid <= 1'b0;
      end
    end
  end

endmodule
